alu_operand_stage: RTL and testbench

//  Operand-fetch/issue stage directly upstream of the RV32I ALU. Takes decoded instruction fields,

---
 rtl/riscv_alu_pkg.sv | 32 +++
 rtl/alu_operand_stage_if.sv | 42 ++++
 rtl/reg_file_2r1w.sv | 35 +++
 rtl/alu_operand_stage.sv | 114 +++++++++++
 tb/tb_alu_operand_stage.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_alu_pkg.sv
// Shared RV32I ALU definitions: widths, opcode encodings and operand-select codes.
package riscv_alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned REG_AW   = $clog2(NREGS);
  localparam int unsigned OPCODE_W = 4;

  // ALU opcode = {funct7[5], funct3}
  localparam logic [OPCODE_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OPCODE_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [OPCODE_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [OPCODE_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [OPCODE_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [OPCODE_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OPCODE_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [OPCODE_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [OPCODE_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [OPCODE_W-1:0] ALU_AND  = 4'b0111;

  localparam logic OP1_SEL_RS1 = 1'b0;
  localparam logic OP1_SEL_PC  = 1'b1;
  localparam logic OP2_SEL_RS2 = 1'b0;
  localparam logic OP2_SEL_IMM = 1'b1;

  // True when a write-back this cycle targets a real (non-x0) register matching raddr.
  function automatic logic wb_hits(logic en, logic [REG_AW-1:0] waddr,
                                   logic [REG_AW-1:0] raddr);
    return en && (waddr != '0) && (waddr == raddr);
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode/write-back/execute signal bundle around the ALU operand stage.
interface alu_operand_stage_if;
  import riscv_alu_pkg::*;

  logic                dec_valid_in;
  logic                dec_ready_out;
  logic [REG_AW-1:0]   rs1_addr_in;
  logic [REG_AW-1:0]   rs2_addr_in;
  logic [REG_AW-1:0]   rd_addr_in;
  logic [XLEN-1:0]     imm_in;
  logic [XLEN-1:0]     pc_in;
  logic                op1_sel_in;
  logic                op2_sel_in;
  logic [OPCODE_W-1:0] alu_opcode_in;
  logic                wb_en_in;
  logic [REG_AW-1:0]   wb_addr_in;
  logic [XLEN-1:0]     wb_data_in;
  logic                flush_in;
  logic                ex_valid_out;
  logic                ex_ready_in;
  logic [XLEN-1:0]     op_1_out;
  logic [XLEN-1:0]     op_2_out;
  logic [OPCODE_W-1:0] opcode_out;
  logic [REG_AW-1:0]   rd_addr_out;

  // The operand stage itself
  modport slave (
    input  dec_valid_in, rs1_addr_in, rs2_addr_in, rd_addr_in, imm_in, pc_in,
    input  op1_sel_in, op2_sel_in, alu_opcode_in, wb_en_in, wb_addr_in, wb_data_in,
    input  flush_in, ex_ready_in,
    output dec_ready_out, ex_valid_out, op_1_out, op_2_out, opcode_out, rd_addr_out
  );

  // Decoder / write-back / execute side
  modport master (
    output dec_valid_in, rs1_addr_in, rs2_addr_in, rd_addr_in, imm_in, pc_in,
    output op1_sel_in, op2_sel_in, alu_opcode_in, wb_en_in, wb_addr_in, wb_data_in,
    output flush_in, ex_ready_in,
    input  dec_ready_out, ex_valid_out, op_1_out, op_2_out, opcode_out, rd_addr_out
  );

endinterface

// File: rtl/reg_file_2r1w.sv
// Integer register file: two async read ports, one sync write port, x0 hard-wired to zero.
module reg_file_2r1w
  import riscv_alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [XLEN-1:0]   rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [XLEN-1:0]   rdata_b_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Storage: clear on reset, commit writes except to x0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: x0 reads zero regardless of storage contents
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch/issue stage ahead of the RV32I ALU: register read with write-back bypass,
// operand selection and a single registered valid/ready slot with stall-time refresh.
module alu_operand_stage
  import riscv_alu_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n_in,
  alu_operand_stage_if.slave bus
);

  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [XLEN-1:0] rs1_val, rs2_val, op1_sel_val, op2_sel_val;
  logic            load, stall;

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [REG_AW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic                op1_sel_q, op1_sel_d, op2_sel_q, op2_sel_d;

  reg_file_2r1w u_reg_file (
    .clk_i     (clk_in),
    .rst_ni    (rst_n_in),
    .raddr_a_i (bus.rs1_addr_in),
    .rdata_a_o (rf_rdata1),
    .raddr_b_i (bus.rs2_addr_in),
    .rdata_b_o (rf_rdata2),
    .we_i      (bus.wb_en_in),
    .waddr_i   (bus.wb_addr_in),
    .wdata_i   (bus.wb_data_in)
  );

  // Operand read with same-cycle write-back bypass, then reg/PC and reg/imm selection
  always_comb begin
    rs1_val = wb_hits(bus.wb_en_in, bus.wb_addr_in, bus.rs1_addr_in) ? bus.wb_data_in
                                                                      : rf_rdata1;
    rs2_val = wb_hits(bus.wb_en_in, bus.wb_addr_in, bus.rs2_addr_in) ? bus.wb_data_in
                                                                      : rf_rdata2;
    op1_sel_val = (bus.op1_sel_in == OP1_SEL_PC)  ? bus.pc_in  : rs1_val;
    op2_sel_val = (bus.op2_sel_in == OP2_SEL_IMM) ? bus.imm_in : rs2_val;
  end

  assign bus.dec_ready_out = !valid_q || bus.ex_ready_in;
  assign load  = bus.dec_valid_in && bus.dec_ready_out && !bus.flush_in;
  assign stall = valid_q && !bus.ex_ready_in;

  // Slot next state: flush beats load, load beats hold; held register operands
  // pick up write-backs while stalled so the ALU never sees a stale value
  always_comb begin
    valid_d   = valid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    op1_sel_d = op1_sel_q;
    op2_sel_d = op2_sel_q;
    if (bus.flush_in) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      op1_d     = op1_sel_val;
      op2_d     = op2_sel_val;
      opcode_d  = bus.alu_opcode_in;
      rd_d      = bus.rd_addr_in;
      rs1_d     = bus.rs1_addr_in;
      rs2_d     = bus.rs2_addr_in;
      op1_sel_d = bus.op1_sel_in;
      op2_sel_d = bus.op2_sel_in;
    end else if (stall) begin
      if (op1_sel_q == OP1_SEL_RS1 && wb_hits(bus.wb_en_in, bus.wb_addr_in, rs1_q)) begin
        op1_d = bus.wb_data_in;
      end
      if (op2_sel_q == OP2_SEL_RS2 && wb_hits(bus.wb_en_in, bus.wb_addr_in, rs2_q)) begin
        op2_d = bus.wb_data_in;
      end
    end else if (valid_q) begin
      valid_d = 1'b0;
    end
  end

  // Issue register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op1_sel_q <= 1'b0;
      op2_sel_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      op1_sel_q <= op1_sel_d;
      op2_sel_q <= op2_sel_d;
    end
  end

  assign bus.ex_valid_out = valid_q;
  assign bus.op_1_out     = op1_q;
  assign bus.op_2_out     = op2_q;
  assign bus.opcode_out   = opcode_q;
  assign bus.rd_addr_out  = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, issue, bypass/x0, stall refresh,
// back-to-back throughput and flush.
module tb_alu_operand_stage;
  import riscv_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_operand_stage_if bus ();

  alu_operand_stage u_dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.dec_valid_in  = 1'b0;
    bus.rs1_addr_in   = '0;
    bus.rs2_addr_in   = '0;
    bus.rd_addr_in    = '0;
    bus.imm_in        = '0;
    bus.pc_in         = '0;
    bus.op1_sel_in    = 1'b0;
    bus.op2_sel_in    = 1'b0;
    bus.alu_opcode_in = '0;
    bus.wb_en_in      = 1'b0;
    bus.wb_addr_in    = '0;
    bus.wb_data_in    = '0;
    bus.flush_in      = 1'b0;
    bus.ex_ready_in   = 1'b1;
  endtask

  task automatic drive_issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic s1, input logic s2, input logic [31:0] imm,
                             input logic [31:0] pc, input logic [3:0] opc);
    bus.dec_valid_in  = 1'b1;
    bus.rs1_addr_in   = rs1;
    bus.rs2_addr_in   = rs2;
    bus.rd_addr_in    = rd;
    bus.op1_sel_in    = s1;
    bus.op2_sel_in    = s2;
    bus.imm_in        = imm;
    bus.pc_in         = pc;
    bus.alu_opcode_in = opc;
  endtask

  task automatic drive_wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en_in   = 1'b1;
    bus.wb_addr_in = addr;
    bus.wb_data_in = data;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b0 || bus.dec_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle got valid=%b ready=%b want valid=0 ready=1",
               bus.ex_valid_out, bus.dec_ready_out);
    end
    // Write x5 and issue a PC/imm op in the same cycle, then stall and reset asynchronously
    drive_wb(5'd5, 32'h0000_1234);
    drive_issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h7, 32'h100, ALU_OR);
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b1 || bus.op_1_out !== 32'h100 || bus.op_2_out !== 32'h7) begin
      errors++;
      $display("FAIL reset_preload got valid=%b op1=%h op2=%h want 1 00000100 00000007",
               bus.ex_valid_out, bus.op_1_out, bus.op_2_out);
    end
    drive_idle();
    bus.ex_ready_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ex_valid_out !== 1'b0 || bus.op_1_out !== 32'h0 || bus.op_2_out !== 32'h0 ||
        bus.opcode_out !== 4'h0 || bus.rd_addr_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_async got valid=%b op1=%h op2=%h opc=%h rd=%0d want all zero",
               bus.ex_valid_out, bus.op_1_out, bus.op_2_out, bus.opcode_out, bus.rd_addr_out);
    end
    #2;
    rst_n = 1'b1;
    bus.ex_ready_in = 1'b1;
    drive_issue(5'd5, 5'd0, 5'd1, 1'b0, 1'b1, 32'h0, 32'h0, ALU_ADD);
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b1 || bus.op_1_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_x5 got valid=%b op1=%h want valid=1 op1=00000000",
               bus.ex_valid_out, bus.op_1_out);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_basic();
    drive_idle();
    drive_wb(5'd1, 32'h1);
    tick();
    drive_idle();
    drive_issue(5'd1, 5'd0, 5'd3, 1'b0, 1'b1, 32'h1, 32'h0, ALU_ADD);
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b1 || bus.op_1_out !== 32'h1 || bus.op_2_out !== 32'h1 ||
        bus.opcode_out !== 4'b0000 || bus.rd_addr_out !== 5'd3) begin
      errors++;
      $display("FAIL basic_issue got valid=%b op1=%h op2=%h opc=%b rd=%0d want 1 1 1 0000 3",
               bus.ex_valid_out, bus.op_1_out, bus.op_2_out, bus.opcode_out, bus.rd_addr_out);
    end
    drive_idle();
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain got valid=%b want 0", bus.ex_valid_out);
    end
  endtask

  task automatic test_bypass();
    drive_idle();
    drive_wb(5'd2, 32'h2);
    drive_issue(5'd2, 5'd0, 5'd4, 1'b0, 1'b1, 32'h10, 32'h0, ALU_SUB);
    tick();
    checks++;
    if (bus.op_1_out !== 32'h2 || bus.opcode_out !== ALU_SUB) begin
      errors++;
      $display("FAIL bypass_rs1 got op1=%h opc=%b want 00000002 1000",
               bus.op_1_out, bus.opcode_out);
    end
    drive_idle();
    drive_wb(5'd0, 32'hDEAD_BEEF);
    tick();
    drive_idle();
    drive_issue(5'd2, 5'd0, 5'd5, 1'b0, 1'b0, 32'h0, 32'h0, ALU_ADD);
    tick();
    checks++;
    if (bus.op_2_out !== 32'h0 || bus.op_1_out !== 32'h2) begin
      errors++;
      $display("FAIL bypass_x0 got op1=%h op2=%h want 00000002 00000000",
               bus.op_1_out, bus.op_2_out);
    end
  endtask

  task automatic test_stall();
    drive_idle();
    drive_wb(5'd4, 32'h11);
    tick();
    drive_idle();
    drive_issue(5'd2, 5'd4, 5'd7, 1'b0, 1'b0, 32'h0, 32'h0, ALU_XOR);
    bus.ex_ready_in = 1'b0;
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b1 || bus.op_2_out !== 32'h11) begin
      errors++;
      $display("FAIL stall_load got valid=%b op2=%h want 1 00000011",
               bus.ex_valid_out, bus.op_2_out);
    end
    // A different instruction waits upstream while execute is blocked
    drive_issue(5'd1, 5'd1, 5'd8, 1'b1, 1'b1, 32'hAA, 32'hBB, ALU_AND);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.dec_ready_out !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d] got %b want 0", i, bus.dec_ready_out);
      end
      tick();
      checks++;
      if (bus.ex_valid_out !== 1'b1 || bus.rd_addr_out !== 5'd7 || bus.op_2_out !== 32'h11 ||
          bus.op_1_out !== 32'h2 || bus.opcode_out !== ALU_XOR) begin
        errors++;
        $display("FAIL stall_hold[%0d] got valid=%b rd=%0d op1=%h op2=%h want 1 7 2 11",
                 i, bus.ex_valid_out, bus.rd_addr_out, bus.op_1_out, bus.op_2_out);
      end
    end
    drive_wb(5'd4, 32'h55);
    tick();
    checks++;
    if (bus.op_2_out !== 32'h55 || bus.op_1_out !== 32'h2 || bus.rd_addr_out !== 5'd7) begin
      errors++;
      $display("FAIL stall_refresh got op1=%h op2=%h rd=%0d want 00000002 00000055 7",
               bus.op_1_out, bus.op_2_out, bus.rd_addr_out);
    end
    drive_idle();
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got valid=%b want 0", bus.ex_valid_out);
    end
    // Immediate operand must not be refreshed by a write to the held rs2
    drive_issue(5'd2, 5'd4, 5'd6, 1'b0, 1'b1, 32'h99, 32'h0, ALU_OR);
    bus.ex_ready_in = 1'b0;
    tick();
    drive_idle();
    bus.ex_ready_in = 1'b0;
    drive_wb(5'd4, 32'h77);
    tick();
    checks++;
    if (bus.op_2_out !== 32'h99 || bus.ex_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_imm_norefresh got valid=%b op2=%h want 1 00000099",
               bus.ex_valid_out, bus.op_2_out);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      drive_issue(5'd0, 5'd0, 5'(10 + i), 1'b1, 1'b1, 32'(i * 3), 32'(32'h1000 + 4 * i),
                  ALU_ADD);
      tick();
      checks++;
      if (bus.ex_valid_out !== 1'b1 || bus.op_1_out !== 32'(32'h1000 + 4 * i) ||
          bus.op_2_out !== 32'(i * 3) || bus.rd_addr_out !== 5'(10 + i) ||
          bus.dec_ready_out !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d] got valid=%b op1=%h op2=%h rd=%0d want 1 %h %h %0d",
                 i, bus.ex_valid_out, bus.op_1_out, bus.op_2_out, bus.rd_addr_out,
                 32'(32'h1000 + 4 * i), 32'(i * 3), 10 + i);
      end
    end
    drive_idle();
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got valid=%b want 0", bus.ex_valid_out);
    end
  endtask

  task automatic test_flush();
    drive_idle();
    drive_issue(5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 32'h1, 32'h2000, ALU_SLT);
    bus.ex_ready_in = 1'b0;
    tick();
    drive_idle();
    bus.ex_ready_in = 1'b0;
    bus.flush_in    = 1'b1;
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold got valid=%b want 0", bus.ex_valid_out);
    end
    drive_idle();
    drive_issue(5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 32'h1, 32'h2000, ALU_SLT);
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b1 || bus.rd_addr_out !== 5'd20) begin
      errors++;
      $display("FAIL flush_reload got valid=%b rd=%0d want 1 20",
               bus.ex_valid_out, bus.rd_addr_out);
    end
    drive_idle();
    drive_issue(5'd0, 5'd0, 5'd21, 1'b1, 1'b1, 32'h5, 32'h3000, ALU_SRA);
    bus.flush_in = 1'b1;
    drive_wb(5'd6, 32'h66);
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_load got valid=%b want 0", bus.ex_valid_out);
    end
    drive_idle();
    tick();
    checks++;
    if (bus.ex_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_dropped got valid=%b want 0", bus.ex_valid_out);
    end
    drive_issue(5'd6, 5'd4, 5'd22, 1'b0, 1'b0, 32'h0, 32'h0, ALU_SLTU);
    tick();
    checks++;
    if (bus.op_1_out !== 32'h66 || bus.op_2_out !== 32'h77 || bus.rd_addr_out !== 5'd22) begin
      errors++;
      $display("FAIL flush_wb_commit got op1=%h op2=%h rd=%0d want 00000066 00000077 22",
               bus.op_1_out, bus.op_2_out, bus.rd_addr_out);
    end
    drive_idle();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle();
    test_reset();
    test_basic();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
